// File: rtl/mic_pkg.sv
// Shared widths and types for the MEMS microphone capture path.
package mic_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int SLOT_BITS = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t data;
    logic    right;
  } mic_word_t;

endpackage

// File: rtl/mic_sample_fifo.sv
// Synchronous sample FIFO; a push into a full FIFO is accepted when a pop
// retires the head on the same cycle.
module mic_sample_fifo
  import mic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  mic_word_t push_word,
  input  logic      pop,
  output mic_word_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  mic_word_t      mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mic_capture_ctrl.sv
// I2S MEMS microphone sequencer: BCLK/WS generation, MSB-first capture, FIFO.
// Define MIC_STEREO_EN to keep both slots; the default build keeps left only.
module mic_capture_ctrl
  import mic_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                d_in,
  output logic                bclk,
  output logic                ws,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_right,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overflow
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_LSB  = BIT_W'(SAMPLE_W);

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_idx;
  logic [SAMPLE_W-2:0] sh;
  logic                div_wrap;
  logic                rise_stb;
  logic                fall_stb;
  logic                push_stb;
  logic                fifo_full;
  logic                fifo_empty;
  mic_word_t           push_word;
  mic_word_t           head;

  assign div_wrap = enable && (div_cnt == DIV_LAST);
  assign rise_stb = div_wrap && !bclk;
  assign fall_stb = div_wrap && bclk;

`ifdef MIC_STEREO_EN
  assign push_stb = rise_stb && (bit_idx == BIT_LSB);
`else
  assign push_stb = rise_stb && (bit_idx == BIT_LSB) && !ws;
`endif

  // The LSB is taken straight from d_in, so the shifter only holds the upper bits.
  always_comb begin
    push_word.data = {sh, d_in};
`ifdef MIC_STEREO_EN
    push_word.right = ws;
`else
    push_word.right = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_idx <= '0;
      ws      <= 1'b0;
      sh      <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_idx <= '0;
      ws      <= 1'b0;
      sh      <= '0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) bclk <= !bclk;
      if (fall_stb) begin
        if (bit_idx == BIT_LAST) begin
          bit_idx <= '0;
          ws      <= !ws;
        end else begin
          bit_idx <= bit_idx + BIT_W'(1);
        end
      end
      // Bit 0 of each slot is the previous word's tail; sampling starts at bit 1.
      if (rise_stb && (bit_idx != '0) && (bit_idx <= BIT_LSB))
        sh <= {sh[SAMPLE_W-3:0], d_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (push_stb && fifo_full && !sample_ready)
      overflow <= 1'b1;
  end

  mic_sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_stb),
    .push_word(push_word),
    .pop      (sample_ready),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign sample_valid = !fifo_empty;
  assign sample_data  = head.data;
  assign sample_right = head.right;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Scoreboard bench for mic_capture_ctrl: a bench-side I2S microphone drives
// d_in, expected samples are queued when their last bit is driven.
`timescale 1ns/1ps
module tb_mic_capture_ctrl;
  import mic_pkg::*;

  localparam int CLK_DIV  = 8;
  localparam int FD       = 4;
  localparam int SLOT_CYC = 2 * CLK_DIV * SLOT_BITS;
`ifdef MIC_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  typedef struct packed {
    logic                right;
    logic [SAMPLE_W-1:0] data;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                d_in;
  logic                sample_ready;
  logic                bclk;
  logic                ws;
  logic                sample_right;
  logic                sample_valid;
  logic                overflow;
  logic [SAMPLE_W-1:0] sample_data;

  int checks = 0;
  int errors = 0;

  // Reference timing state and expected FIFO contents
  int                  m_div;
  int                  m_bit;
  bit                  m_bclk;
  bit                  m_ws;
  bit                  ovf_exp;
  bit                  rand_words;
  logic [SAMPLE_W-1:0] left_word;
  logic [SAMPLE_W-1:0] right_word;
  exp_t                exp_q[$];

  mic_capture_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .d_in        (d_in),
    .bclk        (bclk),
    .ws          (ws),
    .sample_data (sample_data),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_div   = 0;
    m_bit   = 0;
    m_bclk  = 1'b0;
    m_ws    = 1'b0;
    ovf_exp = 1'b0;
    exp_q.delete();
  endtask

  function automatic bit pushNext();
    return enable && !reset && (m_div == CLK_DIV - 1) && !m_bclk &&
           (m_bit == SAMPLE_W) && (STEREO || !m_ws);
  endfunction

  // One clock per iteration: advance the reference, check outputs, drive d_in.
  task automatic applyStimulus(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      bit                  rise;
      bit                  fall;
      bit                  pop_now;
      bit                  push_now;
      bit                  ws_old;
      logic [SAMPLE_W-1:0] w;
      logic [SAMPLE_W-1:0] cur;
      exp_t                e;
      @(posedge clk);
      pop_now  = (exp_q.size() > 0) && sample_ready;
      push_now = 1'b0;
      ws_old   = m_ws;
      w        = m_ws ? right_word : left_word;
      if (reset) begin
        modelReset();
        pop_now = 1'b0;
      end else if (!enable) begin
        m_div  = 0;
        m_bclk = 1'b0;
        m_ws   = 1'b0;
        m_bit  = 0;
      end else begin
        rise     = (m_div == CLK_DIV - 1) && !m_bclk;
        fall     = (m_div == CLK_DIV - 1) && m_bclk;
        push_now = rise && (m_bit == SAMPLE_W) && (STEREO || !m_ws);
        m_div    = (m_div == CLK_DIV - 1) ? 0 : m_div + 1;
        if (rise) m_bclk = 1'b1;
        if (fall) m_bclk = 1'b0;
        if (fall) begin
          if (m_bit == SLOT_BITS - 1) begin
            m_bit = 0;
            m_ws  = !m_ws;
            if (rand_words) begin
              left_word = SAMPLE_W'($urandom);
              if (STEREO) right_word = SAMPLE_W'($urandom);
            end
          end else begin
            m_bit++;
          end
        end
      end
      if (pop_now) void'(exp_q.pop_front());
      if (push_now) begin
        if (exp_q.size() < FD) begin
          e.right = STEREO && ws_old;
          e.data  = w;
          exp_q.push_back(e);
        end else begin
          ovf_exp = 1'b1;
        end
      end
      #1;
      checkOutput("bclk", 32'(bclk), 32'(m_bclk));
      checkOutput("ws", 32'(ws), 32'(m_ws));
      checkOutput("valid", 32'(sample_valid), 32'(exp_q.size() > 0));
      checkOutput("overflow", 32'(overflow), 32'(ovf_exp));
      if (exp_q.size() > 0) begin
        checkOutput("data", 32'(sample_data), 32'(exp_q[0].data));
        checkOutput("right", 32'(sample_right), 32'(exp_q[0].right));
      end
      cur  = m_ws ? right_word : left_word;
      d_in = (m_bit >= 1 && m_bit <= SAMPLE_W) ? cur[SAMPLE_W - m_bit] : 1'($urandom);
    end
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    d_in         = 1'b0;
    sample_ready = 1'b0;
    rand_words   = 1'b0;
    left_word    = 18'h2A5A5;
    right_word   = STEREO ? 18'h0F0F0 : 18'h3FFFF;
    modelReset();
    applyStimulus(3);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_data", 32'(sample_data), 32'd0);
    reset = 1'b0;

    $display("[TB] known left sample, consumer ready");
    enable       = 1'b1;
    sample_ready = 1'b1;
    for (int n = 0; n < 2 * SLOT_CYC && exp_q.size() == 0; n++) applyStimulus(1);
    checkOutput("t2_valid", 32'(sample_valid), 32'd1);
    checkOutput("t2_data", 32'(sample_data), 32'h2A5A5);
    checkOutput("t2_right", 32'(sample_right), 32'd0);
    rand_words = 1'b1;

    $display("[TB] fill FIFO, then pop on a push cycle");
    sample_ready = 1'b0;
    for (int n = 0; n < 12 * SLOT_CYC && exp_q.size() < FD; n++) applyStimulus(1);
    for (int n = 0; n < 4 * SLOT_CYC && !pushNext(); n++) applyStimulus(1);
    sample_ready = 1'b1;
    applyStimulus(1);
    sample_ready = 1'b0;
    checkOutput("t4_ovf", 32'(overflow), 32'd0);
    checkOutput("t4_valid", 32'(sample_valid), 32'd1);

    $display("[TB] consumer stalled, overflow then drain");
    for (int n = 0; n < 6 * SLOT_CYC && !ovf_exp; n++) applyStimulus(1);
    checkOutput("t3_ovf", 32'(overflow), 32'd1);
    applyStimulus(2 * SLOT_CYC);
    sample_ready = 1'b1;
    applyStimulus(2 * SLOT_CYC);

    $display("[TB] reset mid-frame with data queued");
    sample_ready = 1'b0;
    for (int n = 0; n < 6 * SLOT_CYC && exp_q.size() < 2; n++) applyStimulus(1);
    applyStimulus(37);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("t1_bclk", 32'(bclk), 32'd0);
    checkOutput("t1_ws", 32'(ws), 32'd0);
    checkOutput("t1_valid", 32'(sample_valid), 32'd0);
    checkOutput("t1_data", 32'(sample_data), 32'd0);
    checkOutput("t1_right", 32'(sample_right), 32'd0);
    checkOutput("t1_ovf", 32'(overflow), 32'd0);
    modelReset();
    applyStimulus(2);
    reset        = 1'b0;
    sample_ready = 1'b1;
    applyStimulus(2 * SLOT_CYC);

    $display("[TB] enable dropped mid-slot, then re-enabled");
    for (int n = 0; n < 2 * SLOT_CYC && m_bit != 10; n++) applyStimulus(1);
    enable = 1'b0;
    applyStimulus(1);
    checkOutput("t5_bclk", 32'(bclk), 32'd0);
    checkOutput("t5_ws", 32'(ws), 32'd0);
    applyStimulus(40);
    rand_words = 1'b0;
    left_word  = 18'h15A3C;
    right_word = STEREO ? 18'h0A5A5 : 18'h3FFFF;
    enable     = 1'b1;
    for (int n = 0; n < 2 * SLOT_CYC && exp_q.size() == 0; n++) applyStimulus(1);
    checkOutput("t5_valid", 32'(sample_valid), 32'd1);
    checkOutput("t5_data", 32'(sample_data), 32'h15A3C);
    applyStimulus(2 * SLOT_CYC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
